// File: rtl/image_stream_source.sv
// Raster-order frame source: reads a stored image through a 1-cycle-latency memory and streams it out.
// Optional IMG_SRC_CONTINUOUS_EN: loop frames until stop_i instead of emitting FRAMES frames.
module image_stream_source #(
    parameter int unsigned IMAGE_WIDTH  = 110,
    parameter int unsigned IMAGE_HEIGHT = 103,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 14,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned FRAMES       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  stop_i,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_sof_o,
    output logic                  m_eol_o,
    output logic                  m_eof_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned X_W = $clog2(IMAGE_WIDTH);
    localparam int unsigned Y_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int unsigned F_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    if (64'(BASE_ADDR) + 64'(IMAGE_WIDTH) * 64'(IMAGE_HEIGHT) > (64'd1 << ADDR_WIDTH)) begin : g_addr_range_err
        $error("image_stream_source: image does not fit in ADDR_WIDTH address space");
    end

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sof;
        logic                  eol;
        logic                  eof;
    } pix_t;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                state_q;
    logic [X_W-1:0]        x_q;
    logic [Y_W-1:0]        y_q;
    logic [F_W-1:0]        frame_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  inflight_q;
    logic [2:0]            flags_q;
    pix_t                  head_q, tail_q;
    logic [1:0]            cnt_q;
    logic                  busy_q, done_q, stop_q;

    logic       pop, issue, x_last, y_last, f_last, last_read, unused_c;
    logic [1:0] rem, cnt_d;
    pix_t       in_pix, head_d, tail_d;

    // Issue only while the FIFO plus the in-flight read can still absorb the return.
    assign pop       = (cnt_q != 2'd0) && m_ready_i;
    assign issue     = (state_q == S_RUN) && ((3'(cnt_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
    assign x_last    = (x_q == X_W'(IMAGE_WIDTH - 1));
    assign y_last    = (y_q == Y_W'(IMAGE_HEIGHT - 1));
    assign last_read = issue && x_last && y_last && f_last;

`ifdef IMG_SRC_CONTINUOUS_EN
    assign f_last   = stop_q || stop_i;
    assign unused_c = ^frame_q;
`else
    assign f_last   = (frame_q == F_W'(FRAMES - 1));
    assign unused_c = stop_i ^ stop_q;
`endif

    // Two-entry output FIFO: head drives the stream, tail absorbs one return during a stall.
    always_comb begin
        in_pix = '{data: mem_rdata_i, sof: flags_q[2], eol: flags_q[1], eof: flags_q[0]};
        rem    = cnt_q - 2'(pop);
        head_d = (pop && cnt_q == 2'd2) ? tail_q : head_q;
        tail_d = tail_q;
        if (inflight_q) begin
            if (rem == 2'd0) head_d = in_pix;
            else             tail_d = in_pix;
        end
        cnt_d = rem + 2'(inflight_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            frame_q    <= '0;
            addr_q     <= ADDR_WIDTH'(BASE_ADDR);
            inflight_q <= 1'b0;
            flags_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            if (issue) begin
                flags_q <= {(x_q == '0) && (y_q == '0), x_last, x_last && y_last};
                addr_q  <= (x_last && y_last) ? ADDR_WIDTH'(BASE_ADDR) : addr_q + ADDR_WIDTH'(1);
                if (x_last) begin
                    x_q <= '0;
                    if (y_last) begin
                        y_q     <= '0;
                        frame_q <= (frame_q == F_W'(FRAMES - 1)) ? '0 : frame_q + F_W'(1);
                    end else begin
                        y_q <= y_q + Y_W'(1);
                    end
                end else begin
                    x_q <= x_q + X_W'(1);
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        stop_q  <= 1'b0;
                        x_q     <= '0;
                        y_q     <= '0;
                        frame_q <= '0;
                        addr_q  <= ADDR_WIDTH'(BASE_ADDR);
                    end
                end
                S_RUN: begin
                    if (stop_i)    stop_q  <= 1'b1;
                    if (last_read) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    // No reads are issued here, so an empty next-state FIFO means the run is over.
                    if (cnt_d == 2'd0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_rd_en_o = issue;
    assign mem_addr_o  = addr_q;
    assign m_valid_o   = (cnt_q != 2'd0);
    assign m_data_o    = head_q.data;
    assign m_sof_o     = head_q.sof;
    assign m_eol_o     = head_q.eol;
    assign m_eof_o     = head_q.eof;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_image_stream_source.sv
// Bench for image_stream_source: a 4x3 image, single and double frame runs, backpressure and reset abort.
module tb_image_stream_source;

    logic        clk;
    logic        reset;
    logic        start_a, start_b, stop, ready;
    int          sel;
    int          checks, errors;

    logic        rd_a, rd_b, v_a, v_b, sof_a, sof_b, eol_a, eol_b, eof_a, eof_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [13:0] addr_a, addr_b;
    logic [7:0]  rdata_a, rdata_b, data_a, data_b;

    logic        cv, csof, ceol, ceof, cbusy, cdone, crd;
    logic [7:0]  cdata;
    logic [13:0] caddr;
    logic [10:0] cpix;

    image_stream_source #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(3), .DATA_WIDTH(8), .ADDR_WIDTH(14),
                          .BASE_ADDR(0), .FRAMES(1)) dut_a (
        .clk(clk), .reset(reset), .start_i(start_a), .stop_i(stop),
        .mem_rd_en_o(rd_a), .mem_addr_o(addr_a), .mem_rdata_i(rdata_a),
        .m_valid_o(v_a), .m_ready_i(ready), .m_data_o(data_a),
        .m_sof_o(sof_a), .m_eol_o(eol_a), .m_eof_o(eof_a), .busy_o(busy_a), .done_o(done_a));

    image_stream_source #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(3), .DATA_WIDTH(8), .ADDR_WIDTH(14),
                          .BASE_ADDR(100), .FRAMES(2)) dut_b (
        .clk(clk), .reset(reset), .start_i(start_b), .stop_i(stop),
        .mem_rd_en_o(rd_b), .mem_addr_o(addr_b), .mem_rdata_i(rdata_b),
        .m_valid_o(v_b), .m_ready_i(ready), .m_data_o(data_b),
        .m_sof_o(sof_b), .m_eol_o(eol_b), .m_eof_o(eof_b), .busy_o(busy_b), .done_o(done_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are the address LSBs.
    always @(posedge clk) begin
        if (rd_a) rdata_a <= addr_a[7:0];
        if (rd_b) rdata_b <= addr_b[7:0];
    end

    always_comb begin
        if (sel == 0) begin
            cv = v_a; cdata = data_a; csof = sof_a; ceol = eol_a; ceof = eof_a;
            cbusy = busy_a; cdone = done_a; crd = rd_a; caddr = addr_a;
        end else begin
            cv = v_b; cdata = data_b; csof = sof_b; ceol = eol_b; ceof = eof_b;
            cbusy = busy_b; cdone = done_b; crd = rd_b; caddr = addr_b;
        end
        cpix = {cdata, csof, ceol, ceof};
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct packed {
        logic       start;
        logic       rdy;
        logic       valid;
        logic [7:0] data;
        logic       sof, eol, eof, busy, done, rd;
    } vec_t;

    function automatic vec_t mk(bit st, bit rv, bit v, int d, bit s, bit e, bit f, bit b, bit dn, bit rd);
        vec_t r;
        r = '{start: st, rdy: rv, valid: v, data: 8'(d), sof: s, eol: e, eof: f, busy: b, done: dn, rd: rd};
        return r;
    endfunction

    // Starts a run on the selected DUT and scores every popped pixel against the 4x3 raster.
    task automatic run_stream(input int s, input int n_pix, input int base, input int mode, input int stop_after);
        int          got, first_k, last_k;
        logic        stalled, seen_done;
        logic [10:0] held, exp;
        sel = s; got = 0; first_k = -1; last_k = -1; stalled = 1'b0; seen_done = 1'b0; held = '0;
        ready = 1'b1; stop = 1'b0;
        if (s == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        for (int k = 0; k < 600 && !seen_done; k++) begin
            ready = (mode == 0) || (k % 4 == 0) || (k % 4 == 3);
            stop  = (stop_after >= 0) && (got >= stop_after);
            @(negedge clk);
            if (stalled) chk("hold", {cv, cpix}, {1'b1, held});
            if (cv && ready) begin
                exp = {8'(base + got % 12), got % 12 == 0, got % 4 == 3, got % 12 == 11};
                chk($sformatf("pixel%0d", got), cpix, exp);
                if (first_k < 0) first_k = k;
                last_k = k;
                got++;
            end
            stalled = cv && !ready;
            held    = cpix;
            if (cdone) begin
                seen_done = 1'b1;
                chk("done_idle", {cv, cbusy}, 0);
            end
            @(posedge clk); #1;
        end
        chk("done_seen", seen_done, 1);
        chk("pix_count", got, n_pix);
        if (mode == 0) chk("no_gap", last_k - first_k + 1, n_pix);
        @(negedge clk);
        chk("done_single", cdone, 0);
        @(posedge clk); #1;
        stop = 1'b0; ready = 1'b1;
    endtask

    vec_t vecs[17];

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; stop = 1'b0; ready = 1'b1; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_state", {cv, cpix, cbusy, cdone, crd, caddr}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;

`ifndef IMG_SRC_CONTINUOUS_EN
        //            st rv  v  d  s e f  b dn rd
        vecs[0]  = mk(1, 1,  0, 0, 0,0,0, 0,0,0);
        vecs[1]  = mk(0, 1,  0, 0, 0,0,0, 1,0,1);
        vecs[2]  = mk(0, 1,  0, 0, 0,0,0, 1,0,1);
        vecs[3]  = mk(0, 1,  1, 0, 1,0,0, 1,0,1);
        vecs[4]  = mk(0, 1,  1, 1, 0,0,0, 1,0,1);
        vecs[5]  = mk(0, 1,  1, 2, 0,0,0, 1,0,1);
        vecs[6]  = mk(0, 1,  1, 3, 0,1,0, 1,0,1);
        vecs[7]  = mk(0, 1,  1, 4, 0,0,0, 1,0,1);
        vecs[8]  = mk(0, 1,  1, 5, 0,0,0, 1,0,1);
        vecs[9]  = mk(0, 1,  1, 6, 0,0,0, 1,0,1);
        vecs[10] = mk(0, 1,  1, 7, 0,1,0, 1,0,1);
        vecs[11] = mk(0, 1,  1, 8, 0,0,0, 1,0,1);
        vecs[12] = mk(0, 1,  1, 9, 0,0,0, 1,0,1);
        vecs[13] = mk(0, 1,  1,10, 0,0,0, 1,0,0);
        vecs[14] = mk(0, 1,  1,11, 0,1,1, 1,0,0);
        vecs[15] = mk(0, 1,  0, 0, 0,0,0, 0,1,0);
        vecs[16] = mk(0, 1,  0, 0, 0,0,0, 0,0,0);
        sel = 0;
        for (int i = 0; i < 17; i++) begin
            start_a = vecs[i].start;
            ready   = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {cv, cv ? cdata : 8'h00, cv & csof, cv & ceol, cv & ceof, cbusy, cdone, crd},
                {vecs[i].valid, vecs[i].data, vecs[i].sof, vecs[i].eol, vecs[i].eof,
                 vecs[i].busy, vecs[i].done, vecs[i].rd});
            @(posedge clk); #1;
        end
        start_a = 1'b0;
`endif

        run_stream(0, 12, 0, 1, 0);

`ifndef IMG_SRC_CONTINUOUS_EN
        run_stream(1, 24, 100, 0, 0);
`else
        run_stream(0, 48, 0, 0, 40);
`endif

        // Extra start mid-run must not restart the frame; then a reset aborts it.
        sel = 0; ready = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 9; k++) begin
            start_a = (k == 5);
            @(negedge clk);
            if (k >= 3) chk($sformatf("run_data%0d", k), {cv, cdata, cbusy}, {1'b1, 8'(k - 3), 1'b1});
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_reset", {cv, cpix, cbusy, cdone, crd, caddr}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_idle", {cv, cbusy, cdone, crd}, 0);
        @(posedge clk); #1;
        run_stream(0, 12, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_stream_source.md
# image_stream_source

Parametrised frame source that reads a stored image from a synchronous read memory (1-cycle read latency) and emits it as a raster-order pixel stream with valid/ready backpressure and frame/line sideband flags. It sits at the head of the denoising pipeline, feeding the separable FIR stages, and supports multi-frame runs with optional continuous looping.

## Interface
- IMAGE_WIDTH, 110, pixels per line (≥2)
- IMAGE_HEIGHT, 103, lines per frame (≥1)
- DATA_WIDTH, 8, pixel width in bits
- ADDR_WIDTH, 14, memory address width; BASE_ADDR + IMAGE_WIDTH*IMAGE_HEIGHT − 1 must fit, else elaboration `$error`
- BASE_ADDR, 0, memory address of pixel (0,0)
- FRAMES, 1, frames emitted per start (≥1)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- start  in  1  single-cycle request; sampled only in IDLE
- stop  in  1  continuous-mode terminate request (see Configuration)
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_WIDTH  read address
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_rd_en
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_WIDTH  pixel
- m_sof  out  1  first pixel of frame (x=0,y=0)
- m_eol  out  1  last pixel of line (x=IMAGE_WIDTH−1)
- m_eof  out  1  last pixel of frame
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run

## Operation
- FSM: IDLE → RUN on start; RUN → DRAIN when the last read of the last frame is issued; DRAIN → IDLE when the output buffer is empty and no read is in flight; done pulses on that transition.
- Counters: x (0..W−1), y (0..H−1), frame (0..FRAMES−1) advance on each issued read; x wraps to 0 and y increments at W−1; y wraps and frame increments at H−1. mem_addr = BASE_ADDR + y*W + x, maintained incrementally and reset to BASE_ADDR each frame.
- sof/eol/eof are computed at issue time, delayed alongside the read, and stored with data in a 2-entry output FIFO (data + 3 flags).
- Read issue rule: mem_rd_en=1 only in RUN and only when (FIFO occupancy + in-flight reads − pop this cycle) < 2. This guarantees no returned data is ever dropped.
- Pop occurs when m_valid && m_ready. m_data and the flags hold stable while m_valid=1 and m_ready=0.
- start while busy is ignored. A reset in any state aborts the run, discards in-flight data, and returns to IDLE. No done pulse is generated by a reset.

## Timing
- Reset values: mem_rd_en=0, mem_addr=BASE_ADDR, m_valid=0, m_data=0, m_sof=m_eol=m_eof=0, busy=0, done=0. FIFO is empty and all counters are 0.
- start high in cycle N: busy=1 and first mem_rd_en=1 (addr BASE_ADDR) in N+1; data is captured in N+2; m_valid=1 with m_sof=1 in N+3.
- With m_ready held high, throughput is 1 pixel/clk with no gaps at line or frame boundaries. A frame takes W*H cycles.
- done=1 the cycle after the pop of the final eof pixel. busy=0 in that same cycle, and a new start is accepted from that cycle on.
- m_ready low for any duration causes no loss or duplication. Reads resume so that m_valid is continuous from the cycle after m_ready returns high.

## Configuration
- IMG_SRC_CONTINUOUS_EN defined: after the last frame, the block wraps to frame 0 and keeps running with no gap, ignoring FRAMES. stop (level, sampled in RUN) makes the current frame the final one: DRAIN is entered after its last read, then done. stop asserted exactly on the last pixel read of a frame ends the run at that frame.
- Not defined: stop is ignored and the block emits exactly FRAMES frames per start.

## Test plan
- W=4,H=3,FRAMES=1, m_ready=1, memory holds addr LSBs. Pulse start at cycle 10 → m_valid from cycle 13, data 0..11 on consecutive cycles, m_sof on 0, m_eol on 3/7/11, m_eof on 11, done at cycle 25.
- Same config with m_ready toggling 1,0,0,1 repeating → the same 12-pixel sequence with no drop or duplicate, and data/flags stable during every stall.
- FRAMES=2, BASE_ADDR=100 → 24 pixels emitted from addresses 100..111 twice, m_sof at pixels 0 and 12, and one done pulse.
- Pulse start during RUN, then reset asserted mid-frame → the extra start has no effect. After reset all outputs are at reset values, and a subsequent start replays from pixel 0.
- IMG_SRC_CONTINUOUS_EN defined, stop raised during frame 3 → frames 0–3 are output back-to-back, the stream ends at the eof of frame 3, followed by done.
